// File: rtl/prach_pkg.sv
// Shared constants and types for the PRACH C-Plane scheduler.
package prach_pkg;

  localparam int unsigned NUM_CC    = 3;
  localparam int unsigned NUM_ANT   = 8;
  localparam int unsigned FRAME_LEN = 614400;

  typedef struct packed {
    logic [7:0]   ant_mask;
    logic [16:0]  freq;
    logic [19:0]  time_ofs;
    logic [3:0]   nsym;
    logic [119:0] header;
  } prach_c_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ISSUE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/prach_c_sched_if.sv
// Decoder-side section bus, sample tick and per-CC start request bus.
interface prach_c_sched_if #(
  parameter int unsigned NUM_CC  = prach_pkg::NUM_CC,
  parameter int unsigned NUM_ANT = prach_pkg::NUM_ANT
);

  logic [NUM_CC-1:0][NUM_ANT-1:0] c_valid;
  logic [16:0]                    c_frequency_offset;
  logic [19:0]                    c_time_offset;
  logic [3:0]                     c_num_symbol;
  logic [119:0]                   c_header;
  logic                           tick_en;
  logic [19:0]                    tick_time;
  logic [NUM_CC-1:0]              start_valid;
  logic [NUM_CC-1:0]              start_ready;
  logic [NUM_CC-1:0][7:0]         start_ant_mask;
  logic [NUM_CC-1:0][16:0]        start_freq;
  logic [NUM_CC-1:0][3:0]         start_num_symbol;
  logic [NUM_CC-1:0][119:0]       start_header;
  logic [NUM_CC-1:0]              ovf_pulse;
  logic [NUM_CC-1:0]              err_pulse;

  modport master (
    output c_valid, c_frequency_offset, c_time_offset, c_num_symbol, c_header,
    output tick_en, tick_time, start_ready,
    input  start_valid, start_ant_mask, start_freq, start_num_symbol, start_header,
    input  ovf_pulse, err_pulse
  );

  modport slave (
    input  c_valid, c_frequency_offset, c_time_offset, c_num_symbol, c_header,
    input  tick_en, tick_time, start_ready,
    output start_valid, start_ant_mask, start_freq, start_num_symbol, start_header,
    output ovf_pulse, err_pulse
  );

endinterface

// File: rtl/prach_c_sched_cc.sv
// One carrier: pending-section FIFO with tail merge, and the arm/issue FSM
// that releases the head entry when the frame sample counter reaches it.
module prach_c_sched_cc
  import prach_pkg::prach_c_entry_t, prach_pkg::sched_state_e,
         prach_pkg::IDLE, prach_pkg::ARMED, prach_pkg::ISSUE;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned FRAME_LEN = prach_pkg::FRAME_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sec_valid,
  input  prach_c_entry_t sec,
  input  logic           tick_en,
  input  logic [19:0]    tick_time,
  output logic           start_valid,
  input  logic           start_ready,
  output prach_c_entry_t start_entry,
  output logic           ovf_pulse,
  output logic           err_pulse
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] FULL_XOR  = {1'b1, {AW{1'b0}}};
  localparam logic [19:0] FRAME_LIM = 20'(FRAME_LEN);

  prach_c_entry_t mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr, wr_next, rd_next;
  logic [AW-1:0]  head_idx, tail_idx;
  sched_state_e   state;

  logic empty, full, empty_next, in_range, tail_in_issue;
  logic merge, merge_head, push, pop, ovf, match;
  prach_c_entry_t head_fwd;

  assign head_idx      = rd_ptr[AW-1:0];
  assign tail_idx      = wr_ptr[AW-1:0] - AW'(1);
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = ((wr_ptr ^ rd_ptr) == FULL_XOR);
  assign in_range      = (sec.time_ofs < FRAME_LIM);
  assign tail_in_issue = (state == ISSUE) && ((wr_ptr - rd_ptr) == PTR_ONE);

  assign pop   = (state == ISSUE) && start_ready;
  assign merge = sec_valid && in_range && !empty && !tail_in_issue &&
                 (mem[tail_idx].time_ofs == sec.time_ofs) &&
                 (mem[tail_idx].freq == sec.freq) &&
                 (mem[tail_idx].nsym == sec.nsym);
  assign push  = sec_valid && in_range && !merge && (!full || pop);
  assign ovf   = sec_valid && in_range && !merge && full && !pop;
  assign merge_head = merge && (tail_idx == head_idx);

  assign wr_next    = push ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_next    = pop  ? rd_ptr + PTR_ONE : rd_ptr;
  assign empty_next = (wr_next == rd_next);

  // IDLE with a non-empty FIFO is checked for a match like ARMED, so an entry
  // written at N can already issue on a match at N+1.
  assign match = (state != ISSUE) && !empty && tick_en &&
                 (tick_time == mem[head_idx].time_ofs);

  // A merge into the head in the same cycle as its match must reach the output.
  always_comb begin
    head_fwd = mem[head_idx];
    if (merge_head) head_fwd.ant_mask = head_fwd.ant_mask | sec.ant_mask;
  end

  always_ff @(posedge clk) begin
    if (push)       mem[wr_ptr[AW-1:0]]     <= sec;
    else if (merge) mem[tail_idx].ant_mask <= mem[tail_idx].ant_mask | sec.ant_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_valid <= 1'b0;
      start_entry <= '0;
      ovf_pulse   <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      ovf_pulse <= ovf;
      err_pulse <= sec_valid && !in_range;
      unique case (state)
        IDLE, ARMED: begin
          if (match) begin
            state       <= ISSUE;
            start_valid <= 1'b1;
            start_entry <= head_fwd;
          end else begin
            state <= empty ? IDLE : ARMED;
          end
        end
        ISSUE: begin
          if (pop) begin
            start_valid <= 1'b0;
            state       <= empty_next ? IDLE : ARMED;
          end
        end
        default: begin
          state       <= IDLE;
          start_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/prach_c_sched.sv
// PRACH C-Plane scheduler: fans the shared decoder section bus out to one
// scheduler lane per carrier and collects the per-carrier start requests.
module prach_c_sched #(
  parameter int unsigned NUM_CC    = prach_pkg::NUM_CC,
  parameter int unsigned NUM_ANT   = prach_pkg::NUM_ANT,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned FRAME_LEN = prach_pkg::FRAME_LEN
) (
  input logic            clk,
  input logic            rst_n,
  prach_c_sched_if.slave bus
);

  for (genvar g = 0; g < NUM_CC; g++) begin : g_cc
    prach_pkg::prach_c_entry_t sec, iss;
    logic iss_valid, ovf, err;

    assign sec = '{ant_mask: 8'(bus.c_valid[g][NUM_ANT-1:0]),
                   freq:     bus.c_frequency_offset,
                   time_ofs: bus.c_time_offset,
                   nsym:     bus.c_num_symbol,
                   header:   bus.c_header};

    prach_c_sched_cc #(
      .DEPTH     (DEPTH),
      .FRAME_LEN (FRAME_LEN)
    ) u_cc (
      .clk         (clk),
      .rst_n       (rst_n),
      .sec_valid   (|bus.c_valid[g]),
      .sec         (sec),
      .tick_en     (bus.tick_en),
      .tick_time   (bus.tick_time),
      .start_valid (iss_valid),
      .start_ready (bus.start_ready[g]),
      .start_entry (iss),
      .ovf_pulse   (ovf),
      .err_pulse   (err)
    );

    assign bus.start_valid[g]      = iss_valid;
    assign bus.start_ant_mask[g]   = iss.ant_mask;
    assign bus.start_freq[g]       = iss.freq;
    assign bus.start_num_symbol[g] = iss.nsym;
    assign bus.start_header[g]     = iss.header;
    assign bus.ovf_pulse[g]        = ovf;
    assign bus.err_pulse[g]        = err;
  end

endmodule

// File: doc/prach_c_sched.md
# prach_c_sched

Per-carrier scheduler that sits directly downstream of the PRACH C-Plane decoder in the `clk_eth_xran` domain. It takes the decoded per-CC/per-antenna section strobes, frequency offset, time offset, symbol count and header. Sections that share a CC and timing are merged into one pending entry per CC, queued, and released to the PRACH extraction datapath when the local frame sample counter reaches the section's time offset.

## Interface
Parameters:
- `NUM_CC`, 3: carriers; fixed by the decoder's RTC-ID table.
- `NUM_ANT`, 8: antennas per CC (4 × N25, 4 × N66).
- `DEPTH`, 2: pending entries per CC; power of two.
- `FRAME_LEN`, 614400: samples per 10 ms frame at 61.44 Msps.

Ports:
- `clk` in 1: `clk_eth_xran`.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `c_valid` in [NUM_CC][NUM_ANT]: one-cycle section strobe from the decoder.
- `c_frequency_offset` in 17: frequency offset; valid with `c_valid`.
- `c_time_offset` in 20: start sample within the frame.
- `c_num_symbol` in 4: number of PRACH symbols.
- `c_header` in 120: U-Plane header template.
- `tick_en` in 1: sample strobe.
- `tick_time` in 20: current sample index in the frame, 0..FRAME_LEN-1.
- `start_valid` out [NUM_CC]: start request to the extraction datapath.
- `start_ready` in [NUM_CC]: downstream accept.
- `start_ant_mask` out [NUM_CC][8]: antennas covered by the request.
- `start_freq` out [NUM_CC][17]: frequency offset for the request.
- `start_num_symbol` out [NUM_CC][4]: symbol count for the request.
- `start_header` out [NUM_CC][120]: header for the request.
- `ovf_pulse` out [NUM_CC]: one-cycle pulse when a section is dropped because the queue is full.
- `err_pulse` out [NUM_CC]: one-cycle pulse when a section is dropped because its time is out of range.

## Operation
- Entry fields: `ant_mask[8]`, `freq[17]`, `time[20]`, `nsym[4]`, `header[120]`.
- Per-CC FIFO, `DEPTH` entries, with a per-CC FSM.
- Ingest, for each CC independently:
  - Strobes for one CC in one cycle are OR-ed into a single antenna mask.
  - `c_time_offset >= FRAME_LEN`: the section is dropped and `err_pulse` fires.
  - **Merge:** the FIFO tail exists, is not the entry in ISSUE, and matches on `time`, `freq` and `nsym`. The new antenna bits are OR-ed into the tail's `ant_mask`. The tail header is kept: the header of the first section wins, and downstream rewrites the RTC-ID per antenna.
  - **Push:** there is no merge candidate and the FIFO is not full. A new entry is pushed.
  - **Full:** the section is dropped and `ovf_pulse` fires.
- FSM per CC:
  - **IDLE:** FIFO not empty → ARMED.
  - **ARMED:** `tick_en && tick_time == head.time` → ISSUE. The output registers are loaded from the head entry.
  - **ISSUE:** `start_valid` = 1 and the outputs hold stable. When `start_valid && start_ready`, the head is popped. The FSM then goes to ARMED if the FIFO still holds entries, otherwise to IDLE.
- A head time already passed in the frame waits for the next frame occurrence; there is no late-start logic.
- Push and pop on the same CC in the same cycle are both honoured. Count is unchanged, and the push targets the slot freed by the pop.
- A merge into the head is impossible once the FSM is in ISSUE. In ARMED, a merge into the head is allowed and updates the mask before the issue.
- Pointer wrap is modulo `DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Timing
- Reset values: FSMs IDLE, FIFOs empty, `start_valid` = 0, all `start_*` buses 0, both pulse outputs 0.
- Ingest latency: `c_valid` at cycle N → entry or merge visible at N+1. The earliest possible issue match is at N+1.
- Issue latency: match at cycle T → `start_valid` high at T+1.
- `start_valid` has no combinational path from `start_ready`.
- `ovf_pulse` and `err_pulse` occur at N+1 relative to the dropped `c_valid`.
- `rst_n` asserted mid-ISSUE: `start_valid` drops immediately (asynchronous) and all queued entries are discarded.
- Timing of the `c_*` buses: they are sampled only in cycles where some `c_valid` is high.

## Structure
- `prach_pkg` holds:
  - `NUM_CC`, `NUM_ANT`, `FRAME_LEN`
  - `prach_c_entry_t` packed struct
  - `sched_state_e` {IDLE, ARMED, ISSUE}
- Sub-module `prach_c_sched_cc` contains one CC's FIFO, merge logic and FSM.
- The top level instantiates `NUM_CC` copies of `prach_c_sched_cc` in a generate loop and fans out the shared `c_*` buses.

## Test plan
- **Reset:** hold `rst_n` = 0 → all outputs 0. Release, drive no stimulus → `start_valid` stays 0 for 1000 cycles.
- **Single section:** `c_valid[1][2]`, time = 1234, freq = 0x100, nsym = 1. Drive `tick_time` = 1234 with `tick_en`. Required:
  - `start_valid[1]` high the next cycle.
  - `start_ant_mask[1]` = 8'h04, `start_freq[1]` = 0x100.
  - With `start_ready` = 1, the FIFO empties.
- **Merge:** CC0 antennas 0..7 on consecutive cycles, all with time = 5000 → a single issue with `ant_mask` = 8'hFF and the first section's header.
- **Overflow:** CC2 receives three sections with distinct times and no tick → third section dropped, `ovf_pulse[2]` = 1 once. The two stored entries issue in order.
- **Range and backpressure:** section with time = 614400 → `err_pulse`, nothing queued. Then issue a valid section with `start_ready` = 0 for 10 cycles → `start_valid` and all data stay stable, and a new same-time section becomes a separate FIFO entry rather than merging.
- **Reset mid-issue:** assert `rst_n` while in ISSUE with one more entry queued → `start_valid` drops immediately. After release, no stale issue occurs even when `tick_time` matches.
